mips_mc_controller: RTL and testbench

MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

---
 rtl/mips_mc_controller.sv | 200 ++++++++++++++++++++
 tb/tb_mips_mc_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_controller.sv
`default_nettype none
// ============================================================================
// Module  : mips_mc_controller
// Brief   : Multicycle MIPS control FSM (Moore) with illegal-op flag and
//           retired-instruction counter.
// Revision: 1.0 - initial release
// ============================================================================
module mips_mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Op,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    output logic        IorD,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSrc,
    output logic        PCEn,
    output logic [3:0]  ALUCtrl,
    output logic [3:0]  State,
    output logic        IllegalOp,
    output logic [31:0] InstrCount
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;

    state_t      r_state;
    state_t      w_next;
    logic        r_illegal_op;
    logic [31:0] r_instr_count;
    logic        w_pcwrite;
    logic        w_branch;
    logic        w_rfunct_legal;
    logic [3:0]  w_rtype_alu;
    logic        w_decode_legal;
    logic        w_done;

    always_comb begin
        w_rfunct_legal = 1'b1;
        w_rtype_alu    = c_ALU_ADD;
        case (Funct)
            6'b100000: w_rtype_alu = c_ALU_ADD;
            6'b100010: w_rtype_alu = c_ALU_SUB;
            6'b100100: w_rtype_alu = c_ALU_AND;
            6'b100101: w_rtype_alu = c_ALU_OR;
            6'b101010: w_rtype_alu = c_ALU_SLT;
            default:   w_rfunct_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (Op)
            c_OP_LW, c_OP_SW, c_OP_BEQ, c_OP_ADDI, c_OP_J: w_decode_legal = 1'b1;
            c_OP_RTYPE: w_decode_legal = w_rfunct_legal;
            default:    w_decode_legal = 1'b0;
        endcase
    end

    // Next-state logic; codes 12-15 fall into the default and recover to FETCH.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                if (w_decode_legal) begin
                    case (Op)
                        c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                        c_OP_RTYPE:       w_next = S_RTYPEEX;
                        c_OP_BEQ:         w_next = S_BEQEX;
                        c_OP_ADDI:        w_next = S_ADDIEX;
                        c_OP_J:           w_next = S_JEX;
                        default:          w_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:  w_next = (Op == c_OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next = S_MEMWB;
            S_RTYPEEX: w_next = S_RTYPEWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            default:   w_next = S_FETCH;
        endcase
    end

    always_comb begin
        IorD      = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        PCSrc     = 2'b00;
        ALUCtrl   = c_ALU_ADD;
        w_pcwrite = 1'b0;
        w_branch  = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b01;
                IRWrite   = 1'b1;
                w_pcwrite = 1'b1;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                w_done   = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                w_done   = 1'b1;
            end
            S_RTYPEEX: begin
                ALUSrcA = 1'b1;
                ALUCtrl = w_rtype_alu;
            end
            S_RTYPEWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                w_done   = 1'b1;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                w_done   = 1'b1;
            end
            S_BEQEX: begin
                ALUSrcA  = 1'b1;
                ALUCtrl  = c_ALU_SUB;
                PCSrc    = 2'b01;
                w_branch = 1'b1;
                w_done   = 1'b1;
            end
            S_JEX: begin
                PCSrc     = 2'b10;
                w_pcwrite = 1'b1;
                w_done    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_illegal_op  <= 1'b0;
            r_instr_count <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE && !w_decode_legal)
                r_illegal_op <= 1'b1;
            if (w_done)
                r_instr_count <= r_instr_count + 32'd1;
        end
    end

    assign PCEn       = w_pcwrite | (w_branch & Zero);
    assign State      = r_state;
    assign IllegalOp  = r_illegal_op;
    assign InstrCount = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_mips_mc_controller
// Brief   : Scoreboard bench: per-instruction state plans feed a queue of
//           expected cycle records that a negedge monitor compares.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mips_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic        Zero;
    logic        IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, PCSrc;
    logic        PCEn;
    logic [3:0]  ALUCtrl, State;
    logic        IllegalOp;
    logic [31:0] InstrCount;

    mips_mc_controller dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .PCEn(PCEn), .ALUCtrl(ALUCtrl),
        .State(State), .IllegalOp(IllegalOp), .InstrCount(InstrCount)
    );

    always #5 clk = ~clk;

    // ctl = {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,PCSrc,ALUCtrl}
    typedef struct packed {
        logic [3:0]  st;
        logic [14:0] ctl;
        logic        pcen;
        logic        ill;
        logic [31:0] cnt;
    } rec_t;

    rec_t        q[$];
    int          plan[$];
    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;
    logic [31:0] m_cnt;
    logic        m_ill;

    function automatic logic [3:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b0010;
        endcase
    endfunction

    function automatic bit funct_ok(input logic [5:0] f);
        return f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
               f == 6'b100101 || f == 6'b101010;
    endfunction

    function automatic bit op_known(input logic [5:0] o);
        return o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
               o == 6'b000100 || o == 6'b001000 || o == 6'b000010;
    endfunction

    // State walk of one instruction, written as the per-instruction route.
    task automatic build_plan(input logic [5:0] o, input logic [5:0] f);
        plan = '{0, 1};
        case (o)
            6'b100011: plan = '{0, 1, 2, 3, 4};
            6'b101011: plan = '{0, 1, 2, 5};
            6'b000000: if (funct_ok(f)) plan = '{0, 1, 6, 7};
            6'b001000: plan = '{0, 1, 9, 10};
            6'b000100: plan = '{0, 1, 8};
            6'b000010: plan = '{0, 1, 11};
            default: ;
        endcase
    endtask

    function automatic rec_t expect_rec(input int s, input logic [5:0] f, input logic z);
        rec_t r;
        logic iord, mw, irw, rd, m2r, rw, sa, pcen;
        logic [1:0] sb, ps;
        logic [3:0] alu;
        {iord, mw, irw, rd, m2r, rw, sa, pcen} = '0;
        sb = 2'b00; ps = 2'b00; alu = 4'b0010;
        case (s)
            0:  begin irw = 1; sb = 2'b01; pcen = 1; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  iord = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mw = 1; end
            6:  begin sa = 1; alu = funct_alu(f); end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; alu = 4'b0110; ps = 2'b01; pcen = z; end
            9:  begin sa = 1; sb = 2'b10; end
            10: rw = 1;
            11: begin ps = 2'b10; pcen = 1; end
            default: ;
        endcase
        r.st   = 4'(s);
        r.ctl  = {iord, mw, irw, rd, m2r, rw, sa, sb, ps, alu};
        r.pcen = pcen;
        r.ill  = m_ill;
        r.cnt  = m_cnt;
        return r;
    endfunction

    // zmode: 0/1 fixed Zero, 2 random per cycle. abort_at: plan index with reset high, -1 none.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input int zmode, input int abort_at);
        build_plan(o, f);
        Op = o;
        Funct = f;
        for (int i = 0; i < plan.size(); i++) begin
            Zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            q.push_back(expect_rec(plan[i], f, Zero));
            if (i == abort_at) reset = 1'b1;
            @(posedge clk);
            #1;
            if (i == abort_at) begin
                reset = 1'b0;
                m_cnt = 32'd0;
                m_ill = 1'b0;
                return;
            end
        end
        if (plan.size() == 2) m_ill = 1'b1;
        else                  m_cnt = m_cnt + 32'd1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_cnt = 32'd0;
        m_ill = 1'b0;
    endtask

    always @(negedge clk) begin
        rec_t e, a;
        cycle++;
        if (q.size() > 0) begin
            e = q.pop_front();
            a.st   = State;
            a.ctl  = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                      ALUSrcB, PCSrc, ALUCtrl};
            a.pcen = PCEn;
            a.ill  = IllegalOp;
            a.cnt  = InstrCount;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle%0d state got=%0d want=%0d ctl got=%h want=%h pcen got=%b want=%b ill got=%b want=%b cnt got=%h want=%h",
                         cycle, a.st, e.st, a.ctl, e.ctl, a.pcen, e.pcen, a.ill, e.ill, a.cnt, e.cnt);
            end
        end
    end

    initial begin
        logic [5:0] o, f;
        int k, ab;
        Op = 6'd0; Funct = 6'd0; Zero = 1'b0;
        do_reset();
        run_instr(6'b100011, 6'd0, 2, -1);          // lw
        run_instr(6'b000000, 6'b101010, 2, -1);     // slt
        run_instr(6'b000100, 6'd0, 1, -1);          // beq taken
        run_instr(6'b000100, 6'd0, 0, -1);          // beq not taken
        run_instr(6'b111111, 6'd0, 2, -1);          // illegal op
        run_instr(6'b001000, 6'd0, 2, -1);          // addi, flag stays
        run_instr(6'b000000, 6'b000111, 2, -1);     // illegal funct
        do_reset();
        run_instr(6'b101011, 6'd0, 2, 2);           // sw aborted in MEMADR
        run_instr(6'b101011, 6'd0, 2, -1);
        // Counter wrap: preload near the top, then retire jumps.
        dut.r_instr_count = 32'hFFFF_FFFE;
        m_cnt = 32'hFFFF_FFFE;
        repeat (3) run_instr(6'b000010, 6'd0, 2, -1);
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 7);
            f = 6'($urandom_range(0, 63));
            case (k)
                0: o = 6'b100011;
                1: o = 6'b101011;
                2: begin
                    o = 6'b000000;
                    case ($urandom_range(0, 4))
                        0: f = 6'b100000; 1: f = 6'b100010; 2: f = 6'b100100;
                        3: f = 6'b100101; default: f = 6'b101010;
                    endcase
                end
                3: begin
                    o = 6'b000000;
                    while (funct_ok(f)) f = 6'($urandom_range(0, 63));
                end
                4: o = 6'b000100;
                5: o = 6'b001000;
                6: o = 6'b000010;
                default: begin
                    o = 6'($urandom_range(0, 63));
                    while (op_known(o)) o = 6'($urandom_range(0, 63));
                end
            endcase
            build_plan(o, f);
            ab = ($urandom_range(0, 15) == 0) ? $urandom_range(0, plan.size() - 1) : -1;
            run_instr(o, f, 2, ab);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got=%0d want=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
